// File: rtl/alert_led_pkg.sv
// alert_led_pkg: shared state/mode encodings and constants for the alert LED sequencer
package alert_led_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SNOOZE = 2'd2
  } state_e;
  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_STROBE = 2'd3
  } mode_e;
  localparam int STROBE_PERIOD = 4;
endpackage

// File: rtl/alert_tick_gen.sv
// alert_tick_gen: prescaler counting 0..div, one-cycle tick at terminal count
module alert_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  assign tick = en && (cnt_q == div);
  // clear wins, hold when disabled, wrap to zero on the terminal count
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  // prescaler register, cleared asynchronously
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/alert_led_seq.sv
// alert_led_seq: alert LED pattern sequencer; define ALERT_SNOOZE_EN to add the snooze input and SNOOZE state
module alert_led_seq
  import alert_led_pkg::*;
#(
  parameter int LED_W        = 4,
  parameter int DIV_W        = 8,
  parameter int DUR_W        = 8,
  parameter int SNOOZE_STEPS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alert_start,
  input  logic             alert_stop,
`ifdef ALERT_SNOOZE_EN
  input  logic             snooze,
`endif
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] tick_div,
  input  logic [DUR_W-1:0] duration,
  output logic [LED_W-1:0] led_r,
  output logic [LED_W-1:0] led_g,
  output logic             busy,
  output logic             done
);
  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] step_q, step_d;
  logic [LED_W-1:0] led_r_q, led_r_d, led_g_q, led_g_d;
  logic             busy_q, done_q, done_d;
  logic             clr, tick;
  logic [LED_W-1:0] chase, fill;
  logic             strobe_on;
`ifdef ALERT_SNOOZE_EN
  localparam int SNZ_W = SNOOZE_STEPS > 1 ? $clog2(SNOOZE_STEPS) : 1;
  localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_STEPS - 1);
  logic [SNZ_W-1:0] snz_q, snz_d;
`endif

  alert_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .clr (clr),
    .div (div_q),
    .tick(tick)
  );

  assign chase     = LED_W'(1) << (32'(step_d) % LED_W);
  assign fill      = ~({LED_W{1'b1}} << (32'(step_d) % (LED_W + 1)));
  assign strobe_on = (32'(step_d) % STROBE_PERIOD) == 0;

  // next-state logic: stop beats start, start beats snooze and natural end
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    dur_d   = dur_q;
    step_d  = step_q;
    done_d  = 1'b0;
    clr     = 1'b0;
`ifdef ALERT_SNOOZE_EN
    snz_d   = snz_q;
`endif
    if (state_q == IDLE) begin
      clr = 1'b1;
      if (alert_start && !alert_stop) begin
        state_d = RUN;
        mode_d  = mode_e'(mode);
        div_d   = tick_div;
        dur_d   = duration;
        step_d  = '0;
      end
    end else if (alert_stop) begin
      state_d = IDLE;
      done_d  = 1'b1;
      clr     = 1'b1;
    end else if (alert_start) begin
      state_d = RUN;
      mode_d  = mode_e'(mode);
      div_d   = tick_div;
      dur_d   = duration;
      step_d  = '0;
      clr     = 1'b1;
    end
`ifdef ALERT_SNOOZE_EN
    else if (state_q == SNOOZE) begin
      if (tick) begin
        state_d = snz_q == SNZ_LAST ? RUN : SNOOZE;
        snz_d   = snz_q == SNZ_LAST ? '0 : snz_q + 1'b1;
      end
    end else if (snooze) begin
      state_d = SNOOZE;
      snz_d   = '0;
      clr     = 1'b1;
    end
`endif
    else if (tick) begin
      if (dur_q != '0 && step_q == dur_q - 1'b1) begin
        state_d = IDLE;
        done_d  = 1'b1;
        step_d  = '0;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // pattern decode from the next step so LEDs line up with the registered state
  always_comb begin
    led_r_d = '0;
    led_g_d = '1;
    if (state_d == RUN) begin
      led_r_d = mode_d == MODE_TOGGLE ? {LED_W{~step_d[0]}} :
                mode_d == MODE_CHASE  ? chase :
                mode_d == MODE_FILL   ? fill : {LED_W{strobe_on}};
      led_g_d = mode_d == MODE_TOGGLE ? {LED_W{step_d[0]}} :
                mode_d == MODE_STROBE ? '0 : ~led_r_d;
    end
  end

  // state, latched configuration and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_TOGGLE;
      div_q   <= '0;
      dur_q   <= '0;
      step_q  <= '0;
      led_r_q <= '0;
      led_g_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALERT_SNOOZE_EN
      snz_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      dur_q   <= dur_d;
      step_q  <= step_d;
      led_r_q <= led_r_d;
      led_g_q <= led_g_d;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
`ifdef ALERT_SNOOZE_EN
      snz_q   <= snz_d;
`endif
    end
  end

  assign led_r = led_r_q;
  assign led_g = led_g_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule
